// File: rtl/debug_cmd_defs.sv
// Shared opcodes, reply codes and FSM encoding
// for the host-driven bus debug master.
package debug_cmd_defs;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 9;

    localparam logic [DATA_W-1:0] OP_W = 8'h57;
    localparam logic [DATA_W-1:0] OP_R = 8'h52;
    localparam logic [DATA_W-1:0] OP_H = 8'h48;
    localparam logic [DATA_W-1:0] OP_G = 8'h47;

    localparam logic [DATA_W-1:0] RSP_OK  = 8'h2E;
    localparam logic [DATA_W-1:0] RSP_ERR = 8'h3F;

    typedef enum logic [3:0] {
        IDLE,
        ADDR2,
        ADDR1,
        ADDR0,
        COUNT,
        WR_DATA,
        WR_BUS,
        RD_BUS,
        RD_SEND,
        RESP
    } state_t;

    // A count byte of zero requests a full 256-byte burst.
    function automatic logic [CNT_W-1:0] burst_len(
        input logic [DATA_W-1:0] n
    );
        return (n == '0) ? CNT_W'(256) : {1'b0, n};
    endfunction

endpackage

// File: rtl/bus_debug_master_if.sv
// Host byte stream plus system bus signals
// of the debug master, with both-side modports.
interface bus_debug_master_if;
    import debug_cmd_defs::*;

    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic [ADDR_W-1:0] bus_address;
    logic              bus_write_en;
    logic [DATA_W-1:0] bus_data_out;
    logic [DATA_W-1:0] bus_data_in;
    logic              cpu_hold;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        input  bus_data_in,
        output rx_ready, tx_valid, tx_data,
        output bus_address, bus_write_en,
        output bus_data_out, cpu_hold
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        output bus_data_in,
        input  rx_ready, tx_valid, tx_data,
        input  bus_address, bus_write_en,
        input  bus_data_out, cpu_hold
    );

endinterface

// File: rtl/bus_debug_master.sv
// Debug host initiator on the CPU6 bus: loads and
// dumps memory while the CPU is held off the bus.
module bus_debug_master
    import debug_cmd_defs::*;
(
    input  logic                clock,
    input  logic                reset,
    bus_debug_master_if.master  dbg
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic              is_write;
    logic              hold;
    logic [DATA_W-1:0] tx_byte;
    logic [DATA_W-1:0] wr_byte;
    logic              rx_fire;
    logic              tx_fire;
    logic              last;

    assign rx_fire = dbg.rx_valid && dbg.rx_ready;
    assign tx_fire = dbg.tx_valid && dbg.tx_ready;
    assign last    = (remaining == CNT_W'(1));

    assign dbg.bus_address  = addr;
    assign dbg.bus_data_out = wr_byte;
    assign dbg.tx_data      = tx_byte;
    assign dbg.cpu_hold     = hold;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (rx_fire) begin
                if (dbg.rx_data == OP_W ||
                    dbg.rx_data == OP_R)
                    state_nxt = ADDR2;
                else
                    state_nxt = RESP;
            end
            ADDR2:   if (rx_fire) state_nxt = ADDR1;
            ADDR1:   if (rx_fire) state_nxt = ADDR0;
            ADDR0:   if (rx_fire) state_nxt = COUNT;
            COUNT:   if (rx_fire)
                state_nxt = is_write ? WR_DATA : RD_BUS;
            WR_DATA: if (rx_fire) state_nxt = WR_BUS;
            WR_BUS:  state_nxt = last ? RESP : WR_DATA;
            RD_BUS:  state_nxt = RD_SEND;
            RD_SEND: if (tx_fire)
                state_nxt = last ? IDLE : RD_BUS;
            RESP:    if (tx_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dbg.rx_ready     = 1'b0;
        dbg.tx_valid     = 1'b0;
        dbg.bus_write_en = 1'b0;
        unique case (state)
            IDLE, ADDR2, ADDR1, ADDR0, COUNT, WR_DATA:
                dbg.rx_ready = !reset;
            WR_BUS:
                dbg.bus_write_en = 1'b1;
            RD_SEND, RESP:
                dbg.tx_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            is_write  <= 1'b0;
            hold      <= 1'b0;
            tx_byte   <= '0;
            wr_byte   <= '0;
        end else begin
            unique case (state)
                IDLE: if (rx_fire) begin
                    unique case (1'b1)
                        dbg.rx_data == OP_W: begin
                            hold     <= 1'b1;
                            is_write <= 1'b1;
                        end
                        dbg.rx_data == OP_R: begin
                            hold     <= 1'b1;
                            is_write <= 1'b0;
                        end
                        dbg.rx_data == OP_H: begin
                            hold    <= 1'b1;
                            tx_byte <= RSP_OK;
                        end
                        dbg.rx_data == OP_G: begin
                            hold    <= 1'b0;
                            tx_byte <= RSP_OK;
                        end
                        default: tx_byte <= RSP_ERR;
                    endcase
                end
                ADDR2: if (rx_fire)
                    addr[ADDR_W-1:16] <=
                        dbg.rx_data[ADDR_W-17:0];
                ADDR1: if (rx_fire)
                    addr[15:8] <= dbg.rx_data;
                ADDR0: if (rx_fire)
                    addr[7:0] <= dbg.rx_data;
                COUNT: if (rx_fire)
                    remaining <= burst_len(dbg.rx_data);
                WR_DATA: if (rx_fire)
                    wr_byte <= dbg.rx_data;
                WR_BUS: begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    if (last) tx_byte <= RSP_OK;
                end
                // memory read data is combinational on addr
                RD_BUS:
                    tx_byte <= dbg.bus_data_in;
                RD_SEND: if (tx_fire) begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_debug_master.sv
// Directed bench for bus_debug_master with a
// byte-wide RAM model behind the bus.
module tb_bus_debug_master;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nmis  = 0;

    logic [7:0]  mem [0:(1<<19)-1];
    logic [18:0] wa [$];
    logic [7:0]  wd [$];

    bus_debug_master_if bi();

    bus_debug_master dut (
        .clock (clock),
        .reset (reset),
        .dbg   (bi)
    );

    always #5 clock = ~clock;

    assign bi.bus_data_in = mem[bi.bus_address];

    always @(posedge clock) begin
        if (bi.bus_write_en) begin
            mem[bi.bus_address] <= bi.bus_data_out;
            wa.push_back(bi.bus_address);
            wd.push_back(bi.bus_data_out);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bi.rx_valid = 1'b1;
        bi.rx_data  = b;
        while (!bi.rx_ready && n < 50) begin
            step();
            n++;
        end
        if (!bi.rx_ready) begin
            chk("rx_tmo", bi.rx_ready, 1);
            return;
        end
        step();
    endtask

    task automatic send_hdr(input logic [7:0]  op,
                            input logic [18:0] a,
                            input logic [7:0]  n);
        logic [23:0] a24;
        a24 = {5'd0, a};
        send_byte(op);
        send_byte(a24[23:16]);
        send_byte(a24[15:8]);
        send_byte(a24[7:0]);
        send_byte(n);
    endtask

    task automatic recv_byte(input logic [7:0] exp,
                             input int stall,
                             input string tag);
        int n = 0;
        while (!bi.tx_valid && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_vld"}, bi.tx_valid, 1);
        if (!bi.tx_valid) return;
        chk(tag, bi.tx_data, exp);
        repeat (stall) begin
            step();
            chk({tag, "_held"},
                {bi.tx_valid, bi.tx_data},
                {1'b1, exp});
        end
        bi.tx_ready = 1'b1;
        step();
        bi.tx_ready = 1'b0;
    endtask

    task automatic wr_data(input logic [7:0] d);
        send_byte(d);
        chk("wb_rdy", bi.rx_ready, 0);
        chk("wb_we", bi.bus_write_en, 1);
        chk("wb_dat", bi.bus_data_out, d);
    endtask

    initial begin
        int base;
        bi.rx_valid = 1'b0;
        bi.rx_data  = '0;
        bi.tx_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_rdy", bi.rx_ready, 0);
        chk("rst_hold", bi.cpu_hold, 0);
        chk("rst_txv", bi.tx_valid, 0);
        chk("rst_we", bi.bus_write_en, 0);
        chk("rst_addr", bi.bus_address, 0);
        chk("rst_dout", bi.bus_data_out, 0);
        chk("rst_txd", bi.tx_data, 0);
        reset = 1'b0;
        step();
        chk("idle_rdy", bi.rx_ready, 1);

        send_byte(8'h48);
        bi.rx_valid = 1'b0;
        recv_byte(8'h2E, 1, "h_resp");
        chk("h_hold", bi.cpu_hold, 1);
        send_byte(8'h47);
        bi.rx_valid = 1'b0;
        recv_byte(8'h2E, 0, "g_resp");
        chk("g_hold", bi.cpu_hold, 0);
        send_byte(8'h00);
        bi.rx_valid = 1'b0;
        recv_byte(8'h3F, 2, "bad_resp");
        chk("bad_hold", bi.cpu_hold, 0);

        wa.delete();
        wd.delete();
        send_hdr(8'h57, 19'h7FF00, 8'd3);
        chk("w_hold", bi.cpu_hold, 1);
        wr_data(8'hAA);
        wr_data(8'hBB);
        wr_data(8'hCC);
        bi.rx_valid = 1'b0;
        recv_byte(8'h2E, 0, "w_resp");
        chk("w_cnt", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("w_a0", wa[0], 19'h7FF00);
            chk("w_a1", wa[1], 19'h7FF01);
            chk("w_a2", wa[2], 19'h7FF02);
            chk("w_d0", wd[0], 8'hAA);
            chk("w_d1", wd[1], 8'hBB);
            chk("w_d2", wd[2], 8'hCC);
        end
        step();
        chk("w_idle_addr", bi.bus_address, 19'h7FF03);
        chk("w_idle_we", bi.bus_write_en, 0);

        wa.delete();
        wd.delete();
        send_hdr(8'h57, 19'h7FFFF, 8'd2);
        wr_data(8'h11);
        wr_data(8'h22);
        bi.rx_valid = 1'b0;
        recv_byte(8'h2E, 0, "wrap_resp");
        chk("wrap_cnt", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("wrap_a0", wa[0], 19'h7FFFF);
            chk("wrap_a1", wa[1], 19'h00000);
        end
        chk("wrap_m0", mem[19'h7FFFF], 8'h11);
        chk("wrap_m1", mem[19'h00000], 8'h22);

        send_hdr(8'h57, 19'h0FF00, 8'd4);
        for (int i = 1; i <= 4; i++)
            wr_data(8'(i));
        bi.rx_valid = 1'b0;
        recv_byte(8'h2E, 0, "pre_resp");
        wa.delete();
        send_hdr(8'h52, 19'h0FF00, 8'd4);
        bi.rx_valid = 1'b0;
        chk("rd_lat0", bi.tx_valid, 0);
        step();
        chk("rd_lat1", bi.tx_valid, 1);
        recv_byte(8'h01, 0, "rd0");
        recv_byte(8'h02, 2, "rd1");
        recv_byte(8'h03, 1, "rd2");
        recv_byte(8'h04, 3, "rd3");
        chk("rd_end_txv", bi.tx_valid, 0);
        chk("rd_end_rdy", bi.rx_ready, 1);
        step();
        chk("rd_no_dot", bi.tx_valid, 0);
        chk("rd_no_we", wa.size(), 0);

        wa.delete();
        wd.delete();
        send_hdr(8'h57, 19'h01000, 8'd0);
        for (int i = 0; i < 256; i++)
            send_byte(8'(i ^ 8'h5A));
        bi.rx_valid = 1'b0;
        recv_byte(8'h2E, 0, "n0_resp");
        chk("n0_cnt", wa.size(), 256);
        if (wa.size() == 256) begin
            chk("n0_alast", wa[255], 19'h010FF);
            chk("n0_dlast", wd[255], 8'hA5);
            chk("n0_d100", wd[100], 8'h3E);
        end

        send_hdr(8'h57, 19'h02000, 8'd0);
        base = wa.size();
        for (int i = 0; i < 10; i++)
            send_byte(8'(i));
        bi.rx_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        chk("ab_rst_rdy", bi.rx_ready, 0);
        chk("ab_rst_we", bi.bus_write_en, 0);
        reset = 1'b0;
        repeat (4) step();
        chk("ab_cnt", wa.size() - base, 10);
        chk("ab_hold", bi.cpu_hold, 0);
        chk("ab_txv", bi.tx_valid, 0);
        chk("ab_rdy", bi.rx_ready, 1);
        send_byte(8'h41);
        bi.rx_valid = 1'b0;
        recv_byte(8'h3F, 0, "ab_cmd");

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule
